// File: rtl/seq_divider.sv
// Iterative restoring divider: unsigned DW_A-bit dividend / DW_B-bit divisor,
// one quotient bit per clock, start/busy/done handshake with held results.
module seq_divider #(
  parameter int DW_A = 16,
  parameter int DW_B = 8
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            start,
  input  logic [DW_A-1:0] dividend,
  input  logic [DW_B-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [DW_A-1:0] quot,
  output logic [DW_B-1:0] rem,
  output logic            div_zero
);

  localparam int CW = (DW_A > 1) ? $clog2(DW_A) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // a shifts dividend bits out of the top while quotient bits enter at the bottom
  typedef struct packed {
    logic [DW_A-1:0] a;
    logic [DW_B-1:0] r;
    logic [DW_B-1:0] d;
  } work_t;

  state_t          state, state_nxt;
  work_t           wk;
  logic [CW-1:0]   cnt;
  logic [DW_B:0]   rp;
  logic            ge;
  logic [DW_B-1:0] r_nxt;
  logic [DW_A-1:0] a_nxt;
  logic            dz_in;
  logic            accept;

  assign dz_in  = (divisor == '0);
  assign accept = (state == IDLE) && start;

  // r stays below d, so the restored difference always fits in DW_B bits
  always_comb begin
    rp    = {wk.r, wk.a[DW_A-1]};
    ge    = (rp >= {1'b0, wk.d});
    r_nxt = ge ? (rp[DW_B-1:0] - wk.d) : rp[DW_B-1:0];
    a_nxt = {wk.a[DW_A-2:0], ge};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = dz_in ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wk       <= '0;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      wk.a <= dividend;
      wk.r <= '0;
      wk.d <= divisor;
      cnt  <= CW'(DW_A - 1);
      if (dz_in) begin
        quot     <= '1;
        rem      <= dividend[DW_B-1:0];
        div_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      wk.a <= a_nxt;
      wk.r <= r_nxt;
      cnt  <= cnt - 1'b1;
      if (cnt == '0) begin
        quot     <= a_nxt;
        rem      <= r_nxt;
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus random a*b+r vectors.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, div_zero;
  logic [15:0] quot;
  logic [7:0]  rem;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ovl = 0;

  seq_divider #(.DW_A(16), .DW_B(8)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) n_ovl++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result from the bench's own arithmetic, independent of the DUT.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = 8'(a % b); e.dz = 1'b0; e.lat = 17;
    end
    return e;
  endfunction

  // Drives one operation; optionally re-pulses start with other operands mid-run.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                       input exp_t e, input int repulse_at);
    exp_t got;
    int   lat;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(e);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = ~b;
    while (!done && lat < 40) begin
      if (lat == repulse_at) begin
        start = 1'b1; dividend = 16'd200; divisor = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    got = sb.pop_front();
    chk({tag, "_lat"}, lat, got.lat);
    if (done) begin
      chk({tag, "_quot"}, quot, got.q);
      chk({tag, "_rem"}, rem, got.r);
      chk({tag, "_dz"}, div_zero, got.dz);
    end
  endtask

  initial begin
    exp_t e;
    int   ndone;
    logic [15:0] qa;
    logic [7:0]  rb, rr;

    clr_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk); clr_n = 1'b1;

    do_op("d1000_7", 16'd1000, 8'd7, model(16'd1000, 8'd7), -1);
    e = '{q: 16'h008E, r: 8'h06, dz: 1'b0, lat: 17};
    do_op("d1000_7_abs", 16'd1000, 8'd7, e, -1);
    e = '{q: 16'h0101, r: 8'h00, dz: 1'b0, lat: 17};
    do_op("d65535_255", 16'd65535, 8'd255, e, -1);
    e = '{q: 16'h0000, r: 8'd5, dz: 1'b0, lat: 17};
    do_op("d5_200", 16'd5, 8'd200, e, -1);
    e = '{q: 16'hFFFF, r: 8'h34, dz: 1'b1, lat: 1};
    do_op("dz1234", 16'h1234, 8'd0, e, -1);
    e = '{q: 16'd3, r: 8'd1, dz: 1'b0, lat: 17};
    do_op("d10_3", 16'd10, 8'd3, e, -1);

    e = '{q: 16'd11, r: 8'd1, dz: 1'b0, lat: 17};
    do_op("d100_9_repulse", 16'd100, 8'd9, e, 5);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("hold_nodone", ndone, 0);
    chk("hold_quot", quot, 16'd11);
    chk("hold_rem", rem, 8'd1);

    // Abort mid-run: outputs were nonzero (11/1) before the reset.
    @(negedge clk);
    start = 1'b1; dividend = 16'd777; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quot", quot, 0);
    chk("abort_rem", rem, 0);
    chk("abort_dz", div_zero, 0);
    @(negedge clk); clr_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    e = '{q: 16'd10, r: 8'd0, dz: 1'b0, lat: 17};
    do_op("d50_5", 16'd50, 8'd5, e, -1);

    for (int i = 0; i < 2000; i++) begin
      rb = 8'($urandom_range(1, 255));
      qa = 16'($urandom_range(0, (65536 / int'(rb)) - 1));
      rr = 8'($urandom_range(0, int'(rb) - 1));
      e = '{q: qa, r: rr, dz: 1'b0, lat: 17};
      do_op("rnd", 16'(qa * rb + rr), rb, e, -1);
    end

    chk("busy_done_overlap", n_ovl, 0);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
